// File: rtl/serial_uart_bridge.sv
// 8N1 UART bridge between a physical RX/TX line pair and the processor's
// memory-mapped serial port, with a byte FIFO in each direction.
module serial_uart_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic [7:0] serial_data_out,
    output logic       serial_valid_out,
    input  logic       serial_rden_in,
    input  logic [7:0] serial_data_in,
    input  logic       serial_wren_in,
    output logic       serial_ready_out,
    output logic       frame_error_out,
    output logic       rx_overrun_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    logic rx_meta, rxs;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_in;
            rxs     <= rx_meta;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    rx_state_t     rx_state, rx_state_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tick, rx_push, rx_frame_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_tick       = 1'b0;
        rx_push       = 1'b0;
        rx_frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (!rxs) rx_state_next = RX_START;
            RX_START: if (rx_cnt == HALF_LAST) rx_state_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_tick = 1'b1;
                    if (rx_bit == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    if (rxs) begin
                        rx_push       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_frame_err  = 1'b1;
                        rx_state_next = RX_BREAK;
                    end
                end
            end
            // a low stop bit means a break may be in progress: wait for idle
            RX_BREAK: if (rxs) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_state_next != rx_state || rx_tick) rx_cnt <= '0;
            else rx_cnt <= rx_cnt + 1'b1;
            if (rx_state != RX_DATA) rx_bit <= '0;
            else if (rx_tick)        rx_bit <= rx_bit + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_tick) rx_shift <= {rxs, rx_shift[7:1]};
    end

    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wr, rx_rd, rx_rd_next;
    logic        rx_empty, rx_full, rx_pop, rx_write;

    assign rx_empty         = (rx_wr == rx_rd);
    assign rx_full          = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign rx_pop           = serial_rden_in && !rx_empty;
    assign rx_write         = rx_push && (!rx_full || rx_pop);
    assign rx_rd_next       = rx_pop ? rx_rd + PTR_ONE : rx_rd;
    assign serial_valid_out = !rx_empty;

    always_ff @(posedge clock) begin
        if (rx_write) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
    end

    // serial_data_out tracks the head: an existing entry if one remains,
    // otherwise the byte being pushed into an empty FIFO this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wr           <= '0;
            rx_rd           <= '0;
            serial_data_out <= '0;
            rx_overrun_out  <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            if (rx_write) rx_wr <= rx_wr + PTR_ONE;
            rx_rd <= rx_rd_next;
            if (rx_rd_next != rx_wr) serial_data_out <= rx_mem[rx_rd_next[AW-1:0]];
            else if (rx_write)       serial_data_out <= rx_shift;
            if (rx_push && !rx_write) rx_overrun_out <= 1'b1;
            if (rx_frame_err)         frame_error_out <= 1'b1;
        end
    end

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wr, tx_rd;
    logic        tx_empty, tx_full, tx_pop, tx_write;

    assign tx_empty         = (tx_wr == tx_rd);
    assign tx_full          = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign tx_write         = serial_wren_in && (!tx_full || tx_pop);
    assign serial_ready_out = !tx_full;

    always_ff @(posedge clock) begin
        if (tx_write) tx_mem[tx_wr[AW-1:0]] <= serial_data_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_write) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)   tx_rd <= tx_rd + PTR_ONE;
        end
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t     tx_state, tx_state_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_bit_end, tx_shift_en, tx_level;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        tx_pop        = 1'b0;
        tx_shift_en   = 1'b0;
        tx_level      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_level = 1'b0;
                if (tx_bit_end) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_level = tx_shift[0];
                if (tx_bit_end) begin
                    tx_shift_en = 1'b1;
                    if (tx_bit == 3'd7) tx_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                // chain straight into the next frame when more data is queued
                if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_cnt      <= '0;
            tx_bit      <= '0;
            uart_tx_out <= 1'b1;
        end else begin
            if (tx_state == TX_IDLE || tx_state_next != tx_state || tx_shift_en) tx_cnt <= '0;
            else tx_cnt <= tx_cnt + 1'b1;
            if (tx_state != TX_DATA) tx_bit <= '0;
            else if (tx_shift_en)    tx_bit <= tx_bit + 3'd1;
            uart_tx_out <= tx_level;
        end
    end

    always_ff @(posedge clock) begin
        if (tx_pop)           tx_shift <= tx_mem[tx_rd[AW-1:0]];
        else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
    end

endmodule
